// File: rtl/permute_gather_pipe.sv
`default_nettype none
// ============================================================================
// Module   : permute_gather_pipe
// Purpose  : Two-stage valid/ready lane gather, out[k] = in[dest[k]], with
//            out-of-range masking and sticky map-error reporting.
//            Optional bijection check enabled by PERMUTE_GATHER_DUPCHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module permute_gather_pipe #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*W-1:0]      in_bus,
  input  logic [N*SELW-1:0]   dest_bus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*W-1:0]      out_bus,
  output logic [N-1:0]        oob_mask,
  output logic                map_err,
`ifdef PERMUTE_GATHER_DUPCHK_EN
  output logic                dup_err,
`endif
  input  logic                clr_err
);

  localparam logic [SELW:0] c_n_ext = (SELW+1)'(N);

  logic              r_s1_valid;
  logic [N*W-1:0]    r_s1_data;
  logic [N*SELW-1:0] r_s1_dest;
  logic              r_s2_valid;
  logic [N*W-1:0]    r_out_bus;
  logic [N-1:0]      r_oob_mask;
  logic              r_map_err;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_accept;
  logic              w_bad;
  logic [N*W-1:0]    w_gather;
  logic [N-1:0]      w_oob;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = r_s1_valid & w_s2_adv;
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  // Entries compare one bit wider so a full-range SELW code never aliases into range.
  always_comb begin : p_gather
    w_gather = '0;
    w_oob    = '0;
    for (int k = 0; k < N; k++) begin
      if ({1'b0, r_s1_dest[k*SELW +: SELW]} >= c_n_ext) begin
        w_oob[k] = 1'b1;
      end else begin
        for (int j = 0; j < N; j++) begin
          if ({1'b0, r_s1_dest[k*SELW +: SELW]} == (SELW+1)'(j)) begin
            w_gather[k*W +: W] = r_s1_data[j*W +: W];
          end
        end
      end
    end
  end

`ifdef PERMUTE_GATHER_DUPCHK_EN
  localparam int              c_cw  = $clog2(N + 1);
  localparam logic [c_cw-1:0] c_one = c_cw'(1);

  logic w_dup;
  logic r_dup_err;

  // Every lane must be named by exactly one in-range entry.
  always_comb begin : p_dupchk
    logic [c_cw-1:0] cnt;
    w_dup = 1'b0;
    cnt   = '0;
    for (int i = 0; i < N; i++) begin
      cnt = '0;
      for (int k = 0; k < N; k++) begin
        if ({1'b0, r_s1_dest[k*SELW +: SELW]} == (SELW+1)'(i)) begin
          cnt = cnt + c_one;
        end
      end
      if (cnt != c_one) begin
        w_dup = 1'b1;
      end
    end
  end

  assign w_bad   = (|w_oob) | w_dup;
  assign dup_err = r_dup_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dup_err <= 1'b0;
    end else if (w_s1_adv) begin
      r_dup_err <= w_dup;
    end
  end
`else
  assign w_bad = |w_oob;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_dest  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= in_bus;
      r_s1_dest  <= dest_bus;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_bus  <= '0;
      r_oob_mask <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_bus  <= w_gather;
        r_oob_mask <= w_oob;
      end
    end
  end

  // A frame landing in S2 with a bad map takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map_err <= 1'b0;
    end else if (w_s1_adv && w_bad) begin
      r_map_err <= 1'b1;
    end else if (clr_err) begin
      r_map_err <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_bus   = r_out_bus;
  assign oob_mask  = r_oob_mask;
  assign map_err   = r_map_err;

endmodule
`default_nettype wire

// File: tb/tb_permute_gather_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_permute_gather_pipe
// Purpose  : Directed plus random bench for permute_gather_pipe against a
//            frame-queue reference model (PERMUTE_GATHER_DUPCHK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_permute_gather_pipe;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 3;
`ifdef PERMUTE_GATHER_DUPCHK_EN
  localparam bit c_dupchk = 1'b1;
`else
  localparam bit c_dupchk = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N*W-1:0]    in_bus;
  logic [N*SELW-1:0] dest_bus;
  logic              out_valid;
  logic              out_ready;
  logic [N*W-1:0]    out_bus;
  logic [N-1:0]      oob_mask;
  logic              map_err;
  logic              clr_err;
`ifdef PERMUTE_GATHER_DUPCHK_EN
  logic              dup_err;
`endif

  permute_gather_pipe #(.N(N), .W(W), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .dest_bus  (dest_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .oob_mask  (oob_mask),
    .map_err   (map_err),
`ifdef PERMUTE_GATHER_DUPCHK_EN
    .dup_err   (dup_err),
`endif
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] data;
    logic [N-1:0]   oob;
    bit             dup;
    int             t;
    int             id;
  } frame_t;

  frame_t q[$];
  int     total;
  int     bad;
  int     cyc;
  int     next_id;
  int     last_loaded;
  bit     exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*SELW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {SELW'(d3), SELW'(d2), SELW'(d1), SELW'(d0)};
  endfunction

  // Reference gather: each output lane reads the input lane its entry names.
  function automatic frame_t model(input logic [N*W-1:0] d, input logic [N*SELW-1:0] m);
    frame_t f;
    int     cnt [N];
    int     s;
    f.data = '0;
    f.oob  = '0;
    f.dup  = 1'b0;
    f.t    = 0;
    f.id   = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < N; k++) begin
      s = int'(m[k*SELW +: SELW]);
      if (s >= N) f.oob[k] = 1'b1;
      else begin
        f.data[k*W +: W] = d[s*W +: W];
        cnt[s]++;
      end
    end
    for (int i = 0; i < N; i++) if (cnt[i] != 1) f.dup = 1'b1;
    return f;
  endfunction

  function automatic logic [N*W-1:0] scatter(input logic [N*W-1:0] d, input logic [N*SELW-1:0] m);
    logic [N*W-1:0] o;
    int s;
    o = '0;
    for (int j = 0; j < N; j++) begin
      s = int'(m[j*SELW +: SELW]);
      if (s < N) o[s*W +: W] = d[j*W +: W];
    end
    return o;
  endfunction

  // One clock: check the DUT against the model, then advance both.
  task automatic tick(output bit acc);
    bit     exp_v, exp_rdy, xfer, loaded, fbad;
    frame_t f;
    #1;
    exp_rdy = (q.size() < 2) || out_ready;
    exp_v   = (q.size() > 0) && (cyc - q[0].t >= 2);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_v);
    chk("map_err", map_err, exp_err);
    if (exp_v) begin
      chk("out_bus", out_bus, q[0].data);
      chk("oob_mask", oob_mask, q[0].oob);
`ifdef PERMUTE_GATHER_DUPCHK_EN
      chk("dup_err", dup_err, q[0].dup);
`endif
    end
    acc  = in_valid && exp_rdy;
    xfer = exp_v && out_ready;
    f    = model(in_bus, dest_bus);
    f.t  = cyc;
    f.id = next_id;
    @(posedge clk);
    cyc++;
    if (xfer) void'(q.pop_front());
    if (acc) begin
      q.push_back(f);
      next_id++;
    end
    loaded = (q.size() > 0) && (cyc - q[0].t >= 2) && (q[0].id != last_loaded);
    fbad   = 1'b0;
    if (loaded) begin
      last_loaded = q[0].id;
      fbad = (q[0].oob != '0) || (c_dupchk && q[0].dup);
    end
    if (loaded && fbad) exp_err = 1'b1;
    else if (clr_err)   exp_err = 1'b0;
    #1;
  endtask

  task automatic set_in(input bit v, input logic [N*W-1:0] d, input logic [N*SELW-1:0] m);
    in_valid = v;
    in_bus   = d;
    dest_bus = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  localparam logic [N*W-1:0] c_base = 32'h44332211;

  initial begin
    bit             acc;
    int             fidx;
    logic [N*W-1:0] frames [4];
    logic [N*W-1:0] scat;
    logic [N*SELW-1:0] m;

    total = 0; bad = 0; cyc = 0; next_id = 0; last_loaded = -1; exp_err = 1'b0;
    rst_n = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    set_in(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bus", out_bus, '0);
    chk("rst_oob", oob_mask, '0);
    chk("rst_map_err", map_err, 1'b0);
    rst_n = 1'b1;

    // Identity map, two-cycle latency.
    out_ready = 1'b1;
    set_in(1'b1, c_base, pack(0, 1, 2, 3));
    tick(acc);
    set_in(1'b0, '0, '0);
    tick(acc);
    chk("ident_valid", out_valid, 1'b1);
    chk("ident_bus", out_bus, 32'h44332211);
    tick(acc);

    // Reversal.
    set_in(1'b1, c_base, pack(3, 2, 1, 0));
    tick(acc);
    set_in(1'b0, '0, '0);
    tick(acc);
    chk("rev_bus", out_bus, 32'h11223344);
    tick(acc);

    // Scatter then gather with the same map restores lane order.
    m    = pack(2, 0, 3, 1);
    scat = scatter(c_base, m);
    set_in(1'b1, scat, m);
    tick(acc);
    set_in(1'b0, '0, '0);
    tick(acc);
    chk("roundtrip_bus", out_bus, 32'h44332211);
    tick(acc);

    // Back-pressure: four frames against a stalled sink, then release.
    frames[0] = 32'ha0a1a2a3; frames[1] = 32'hb0b1b2b3;
    frames[2] = 32'hc0c1c2c3; frames[3] = 32'hd0d1d2d3;
    out_ready = 1'b0;
    fidx = 0;
    for (int c = 0; c < 5; c++) begin
      if (fidx < 4) set_in(1'b1, frames[fidx], pack(0, 1, 2, 3));
      else          set_in(1'b0, '0, '0);
      tick(acc);
      if (acc) fidx++;
    end
    chk("bp_hold_bus", out_bus, 32'ha0a1a2a3);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (fidx < 4) set_in(1'b1, frames[fidx], pack(0, 1, 2, 3));
      else          set_in(1'b0, '0, '0);
      tick(acc);
      if (acc) fidx++;
    end

    // Out-of-range entry, sticky error, clear, and set-beats-clear.
    set_in(1'b1, c_base, pack(0, 5, 2, 3));
    tick(acc);
    set_in(1'b0, '0, '0);
    tick(acc);
    chk("oob_bus", out_bus, 32'h44330011);
    chk("oob_mask", oob_mask, 4'b0010);
    chk("oob_err", map_err, 1'b1);
    tick(acc);
    tick(acc);
    clr_err = 1'b1;
    tick(acc);
    clr_err = 1'b0;
    chk("clr_err", map_err, 1'b0);
    set_in(1'b1, c_base, pack(6, 1, 2, 3));
    tick(acc);
    set_in(1'b0, '0, '0);
    clr_err = 1'b1;
    tick(acc);
    clr_err = 1'b0;
    chk("set_wins", map_err, 1'b1);
    clr_err = 1'b1;
    tick(acc);
    clr_err = 1'b0;

    // Duplicate entries: gather still reads per lane.
    set_in(1'b1, c_base, pack(1, 1, 2, 3));
    tick(acc);
    set_in(1'b0, '0, '0);
    tick(acc);
    chk("dup_bus", out_bus, 32'h44332222);
    chk("dup_map_err", map_err, c_dupchk);
`ifdef PERMUTE_GATHER_DUPCHK_EN
    chk("dup_flag", dup_err, 1'b1);
`endif
    tick(acc);
    clr_err = 1'b1;
    tick(acc);
    clr_err = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      m = '0;
      for (int k = 0; k < N; k++) m[k*SELW +: SELW] = SELW'($urandom_range(0, 4));
      set_in(($urandom % 4) != 0, $urandom, m);
      out_ready = ($urandom % 3) != 0;
      clr_err   = ($urandom % 8) == 0;
      tick(acc);
    end
    clr_err = 1'b0;

    // Reset with both stages full and the error flag set.
    out_ready = 1'b1;
    set_in(1'b0, '0, '0);
    for (int c = 0; c < 4; c++) tick(acc);
    out_ready = 1'b0;
    set_in(1'b1, 32'h55667788, pack(7, 1, 2, 3));
    tick(acc);
    set_in(1'b1, 32'h99aabbcc, pack(0, 1, 2, 3));
    tick(acc);
    set_in(1'b0, '0, '0);
    tick(acc);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_bus", out_bus, '0);
    chk("mid_rst_oob", oob_mask, '0);
    chk("mid_rst_err", map_err, 1'b0);
    q.delete();
    exp_err = 1'b0;
    last_loaded = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
